elastic_stage_reg: RTL and testbench
====================================

# elastic_stage_reg

Parametrised pipeline stage register with a valid/ready handshake and a 2-entry skid buffer. It generalises the fixed stall/flush stage registers between the fetch, decode, execute, memory and writeback stages to any payload width. Upstream back-pressure is registered, so `ready_o` never depends combinationally on `ready_i`. Flush drops everything held, and bubbles present a configurable payload (e.g. a NOP encoding). It is placed between any two pipeline stages that need back-pressure rather than global stalls.

## Interface
- `WIDTH`, default 97: payload width in bits.
- `RESET_DATA`, default `'0`: `[WIDTH-1:0]` value loaded into the output register on reset, flush and bubble.
- `BUBBLE_CLEAR`, default 1: when 1, `data_o` = `RESET_DATA` whenever `valid_o`=0. When 0, `data_o` holds its last value.
- `clk_i`, in, 1: the single clock. All state changes on its rising edge.
- `reset_n_i`, in, 1: asynchronous, active-low reset.
- `valid_i`, in, 1: upstream payload valid.
- `ready_o`, out, 1: stage can accept. Registered.
- `data_i`, in, WIDTH: upstream payload.
- `valid_o`, out, 1: downstream payload valid. Registered.
- `ready_i`, in, 1: downstream accepts.
- `data_o`, out, WIDTH: downstream payload. Registered.
- `flush_i`, in, 1: synchronous squash of all held entries.
- `occupancy_o`, out, 2: number of held entries (0–2).

## Operation
- Upstream transfer occurs when `valid_i & ready_o`. Downstream transfer occurs when `valid_o & ready_i`.
- Storage is a main register (drives `data_o`) plus a skid register.
- FSM states:
  - `ST_EMPTY`: 0 entries.
  - `ST_BUSY`: main register valid.
  - `ST_FULL`: main and skid valid.
- `ready_o` = (state != `ST_FULL`). `valid_o` = (state != `ST_EMPTY`). `occupancy_o` = 0, 1 or 2 respectively.
- Transitions when `flush_i`=0:
  - `ST_EMPTY`:
    - `valid_i` → `ST_BUSY`, main ← `data_i`.
    - Otherwise hold.
  - `ST_BUSY`:
    - `valid_i & ready_i` → stay, main ← `data_i`.
    - `valid_i & ~ready_i` → `ST_FULL`, skid ← `data_i`.
    - `~valid_i & ready_i` → `ST_EMPTY`; main ← `RESET_DATA` if `BUBBLE_CLEAR`.
    - Neither → hold.
  - `ST_FULL`:
    - `ready_i` → `ST_BUSY`, main ← skid.
    - Otherwise hold. `valid_i` is ignored because `ready_o`=0.
- `flush_i`=1 has the highest priority:
  - Next state is `ST_EMPTY`, main ← `RESET_DATA`, skid contents are don't-care.
  - A same-cycle upstream payload is dropped even though `ready_o` was 1.
  - A same-cycle downstream transfer still completes; the consumer owns that payload.
- Ordering is strict FIFO. The skid entry is never bypassed.
- Payload is opaque: no arithmetic is performed and bits pass unmodified.

## Timing
- Reset (asynchronous assert on `reset_n_i`=0, effective immediately; release synchronous to `clk_i`):
  - State = `ST_EMPTY`.
  - `valid_o`=0, `ready_o`=1, `occupancy_o`=0, `data_o`=`RESET_DATA`.
- Reset mid-operation discards all entries with no partial transfer.
- Latency: an accepted payload appears on `data_o` with `valid_o`=1 in the next cycle when the stage was `ST_EMPTY`, or directly behind the occupying entry otherwise.
- Throughput: 1 transfer per cycle sustained while `ready_i`=1.
- Back-pressure: `ready_o` falls one cycle after the first stalled accept (`ST_BUSY`→`ST_FULL`). The skid register absorbs the in-flight payload.
- `ready_o` rises the cycle after `ready_i` drains `ST_FULL`.
- No combinational paths from `ready_i` to `ready_o`, or from `valid_i`/`data_i` to any output.

## Structure
- Shared `pipeline_pkg` holds:
  - The state enum `stage_state_t` {`ST_EMPTY`, `ST_BUSY`, `ST_FULL`}, 2-bit encoding.
  - `OCC_W`=2.
- Single module, no sub-module. The existing `flop` is not reused because it has synchronous active-high reset.
- Decode, execute and memory stage wrappers pack their signal structs and instantiate this block with `WIDTH = $bits(struct)`.

## Test plan
- **Reset:** drive `reset_n_i`=0 mid-`ST_FULL` with `RESET_DATA`=`32'h00000013` → outputs change immediately to `valid_o`=0, `ready_o`=1, `data_o`=`0x13`, `occupancy_o`=0.
- **Streaming:** send `0x1..0x20` with `ready_i`=1 → identical sequence out, one per cycle, at 1-cycle latency. `occupancy_o` stays 1 during the stream.
- **Back-pressure:** in `ST_BUSY` holding `0xA`, present `0xB` with `ready_i`=0 → `ST_FULL`, `ready_o`=0 next cycle. Raise `ready_i` → outputs `0xA` then `0xB`. No loss, no duplicate.
- **Flush with upstream accept:** flush asserted in `ST_FULL` together with `valid_i`=1, `data_i`=`0xC` → next cycle `valid_o`=0, `data_o`=`RESET_DATA`, `0xC` never emitted.
- **Flush with downstream transfer:** flush asserted while `valid_o & ready_i` on `0xD` → `0xD` counted as delivered, stage empty next cycle.
- **Randomised scoreboard:** random `valid_i`/`ready_i` for 10k cycles → in-order delivery with no loss.
  - `ready_o`==(`occupancy_o`<2) every cycle.
  - With `BUBBLE_CLEAR`=0, `data_o` holds its last value when empty.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: stage handshake states and occupancy width.
package pipeline_pkg;

  localparam int OCC_W = 2;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } stage_state_t;

  // Number of entries held in each state.
  function automatic logic [OCC_W-1:0] occ_of(input stage_state_t s);
    logic [OCC_W-1:0] occ;
    case (s)
      ST_EMPTY: occ = 2'd0;
      ST_BUSY:  occ = 2'd1;
      ST_FULL:  occ = 2'd2;
      default:  occ = 2'd0;
    endcase
    return occ;
  endfunction

endpackage

// File: rtl/elastic_stage_reg.sv
// Valid/ready pipeline stage register with a 2-entry skid buffer.
// All outputs are flops; no input reaches an output without a clock edge.
module elastic_stage_reg
  import pipeline_pkg::*;
#(
  parameter int              WIDTH        = 97,
  parameter logic [WIDTH-1:0] RESET_DATA  = '0,
  parameter bit              BUBBLE_CLEAR = 1'b1
) (
  input  logic             clk_i,
  input  logic             reset_n_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] data_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] data_o,
  input  logic             flush_i,
  output logic [OCC_W-1:0] occupancy_o
);

  stage_state_t     state_r, state_nx;
  logic [WIDTH-1:0] main_r, main_nx;
  logic [WIDTH-1:0] skid_r, skid_nx;
  logic             ready_r, valid_r;
  logic [OCC_W-1:0] occ_r;

  // Next-state and datapath selection; flush overrides every transition.
  always_comb begin
    state_nx = state_r;
    main_nx  = main_r;
    skid_nx  = skid_r;
    if (flush_i) begin
      state_nx = ST_EMPTY;
      main_nx  = RESET_DATA;
    end else begin
      case (state_r)
        ST_EMPTY: begin
          if (valid_i) begin
            state_nx = ST_BUSY;
            main_nx  = data_i;
          end else begin
            state_nx = ST_EMPTY;
          end
        end
        ST_BUSY: begin
          if (valid_i && ready_i) begin
            main_nx = data_i;
          end else if (valid_i) begin
            // Stalled accept: park the in-flight payload behind main.
            state_nx = ST_FULL;
            skid_nx  = data_i;
          end else if (ready_i) begin
            state_nx = ST_EMPTY;
            main_nx  = BUBBLE_CLEAR ? RESET_DATA : main_r;
          end else begin
            state_nx = ST_BUSY;
          end
        end
        ST_FULL: begin
          if (ready_i) begin
            state_nx = ST_BUSY;
            main_nx  = skid_r;
          end else begin
            state_nx = ST_FULL;
          end
        end
        default: begin
          state_nx = ST_EMPTY;
          main_nx  = RESET_DATA;
        end
      endcase
    end
  end

  // State, storage and output flags, all updated from the next-state values.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r <= ST_EMPTY;
      main_r  <= RESET_DATA;
      skid_r  <= RESET_DATA;
      ready_r <= 1'b1;
      valid_r <= 1'b0;
      occ_r   <= 2'd0;
    end else begin
      state_r <= state_nx;
      main_r  <= main_nx;
      skid_r  <= skid_nx;
      ready_r <= (state_nx != ST_FULL);
      valid_r <= (state_nx != ST_EMPTY);
      occ_r   <= occ_of(state_nx);
    end
  end

  assign ready_o     = ready_r;
  assign valid_o     = valid_r;
  assign data_o      = main_r;
  assign occupancy_o = occ_r;

endmodule

// File: tb/tb_elastic_stage_reg.sv
// Scoreboard bench: two instances (bubble clear on/off) share random stimulus
// and are compared against a queue-based model of the held entries.
module tb_elastic_stage_reg;

  localparam int          W     = 32;
  localparam logic [W-1:0] RST_D = 32'h00000013;

  logic         clk = 1'b0;
  logic         reset_n_i = 1'b0;
  logic         valid_i = 1'b0;
  logic         ready_i = 1'b0;
  logic         flush_i = 1'b0;
  logic [W-1:0] data_i = 32'h0;

  logic         ready_a, valid_a, ready_b, valid_b;
  logic [W-1:0] data_a, data_b;
  logic [1:0]   occ_a, occ_b;

  int errors = 0;
  int checks = 0;

  logic [W-1:0] held[$];
  logic [W-1:0] last_hold = RST_D;

  always #5 clk = ~clk;

  elastic_stage_reg #(.WIDTH(W), .RESET_DATA(RST_D), .BUBBLE_CLEAR(1'b1)) dut_a (
    .clk_i(clk), .reset_n_i(reset_n_i), .valid_i(valid_i), .ready_o(ready_a),
    .data_i(data_i), .valid_o(valid_a), .ready_i(ready_i), .data_o(data_a),
    .flush_i(flush_i), .occupancy_o(occ_a)
  );

  elastic_stage_reg #(.WIDTH(W), .RESET_DATA(RST_D), .BUBBLE_CLEAR(1'b0)) dut_b (
    .clk_i(clk), .reset_n_i(reset_n_i), .valid_i(valid_i), .ready_o(ready_b),
    .data_i(data_i), .valid_o(valid_b), .ready_i(ready_i), .data_o(data_b),
    .flush_i(flush_i), .occupancy_o(occ_b)
  );

  function automatic void check(input string name, input logic [W-1:0] act,
                                input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  task automatic drive(input logic v, input logic [W-1:0] d, input logic r, input logic f);
    @(posedge clk);
    #1;
    valid_i = v;
    data_i  = d;
    ready_i = r;
    flush_i = f;
  endtask

  // Monitor: compare both DUTs to the model, then advance the model one cycle.
  always @(negedge clk) begin
    logic exp_valid, exp_ready, up, down;
    logic [W-1:0] popped;
    if (!reset_n_i) begin
      held.delete();
      last_hold = RST_D;
      check("rst_valid", W'(valid_a), W'(1'b0));
      check("rst_ready", W'(ready_a), W'(1'b1));
      check("rst_occ",   W'(occ_a),   W'(0));
      check("rst_data",  data_a, RST_D);
      check("rst_data_b", data_b, RST_D);
    end else begin
      exp_valid = (held.size() > 0);
      exp_ready = (held.size() < 2);
      check("ready_a", W'(ready_a), W'(exp_ready));
      check("valid_a", W'(valid_a), W'(exp_valid));
      check("occ_a",   W'(occ_a),   W'(held.size()));
      check("ready_b", W'(ready_b), W'(exp_ready));
      check("valid_b", W'(valid_b), W'(exp_valid));
      check("occ_b",   W'(occ_b),   W'(held.size()));
      if (exp_valid) begin
        check("data_a", data_a, held[0]);
        check("data_b", data_b, held[0]);
      end else begin
        check("bubble_a", data_a, RST_D);
        check("hold_b",   data_b, last_hold);
      end
      down = exp_valid && ready_i;
      up   = valid_i && exp_ready;
      if (down) begin
        popped    = held.pop_front();
        last_hold = popped;
      end
      if (flush_i) begin
        held.delete();
        last_hold = RST_D;
      end else if (up) begin
        held.push_back(data_i);
      end
    end
  end

  initial begin
    logic v, r, f;
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    reset_n_i = 1'b1;

    // Streaming at full rate.
    for (int i = 1; i <= 32; i++) drive(1'b1, W'(i), 1'b1, 1'b0);
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    drive(1'b0, 32'h0, 1'b1, 1'b0);

    // Back-pressure into the skid register.
    drive(1'b1, 32'hA, 1'b0, 1'b0);
    drive(1'b1, 32'hB, 1'b0, 1'b0);
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    #1;
    check("bp_ready_low", W'(ready_a), W'(1'b0));
    check("bp_occ_full",  W'(occ_a),   W'(2));
    check("bp_head",      data_a, 32'hA);
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    drive(1'b0, 32'h0, 1'b1, 1'b0);

    // Flush in FULL with a payload presented upstream.
    drive(1'b1, 32'h1, 1'b0, 1'b0);
    drive(1'b1, 32'h2, 1'b0, 1'b0);
    drive(1'b1, 32'hC, 1'b0, 1'b1);
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    #1;
    check("flush_full_valid", W'(valid_a), W'(1'b0));
    check("flush_full_data",  data_a, RST_D);
    check("flush_full_data_b", data_b, RST_D);

    // Flush in BUSY drops an upstream payload accepted with ready_o=1.
    drive(1'b1, 32'h5, 1'b0, 1'b0);
    drive(1'b1, 32'hC, 1'b0, 1'b1);
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    #1;
    check("flush_busy_valid", W'(valid_a), W'(1'b0));
    check("flush_busy_occ",   W'(occ_a),   W'(0));

    // Flush coinciding with a downstream transfer of 0xD.
    drive(1'b1, 32'hD, 1'b0, 1'b0);
    drive(1'b0, 32'h0, 1'b1, 1'b1);
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    #1;
    check("flush_dn_valid", W'(valid_a), W'(1'b0));
    check("flush_dn_data",  data_a, RST_D);

    // Asynchronous reset while FULL.
    drive(1'b1, 32'h77, 1'b0, 1'b0);
    drive(1'b1, 32'h78, 1'b0, 1'b0);
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    #2;
    reset_n_i = 1'b0;
    #1;
    check("async_rst_valid", W'(valid_a), W'(1'b0));
    check("async_rst_ready", W'(ready_a), W'(1'b1));
    check("async_rst_occ",   W'(occ_a),   W'(0));
    check("async_rst_data",  data_a, RST_D);
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    reset_n_i = 1'b1;

    // Randomised traffic with occasional flushes.
    for (int i = 0; i < 10000; i++) begin
      v = ($urandom_range(0, 99) < 70);
      r = ($urandom_range(0, 99) < ((i / 500) % 2 == 0 ? 60 : 90));
      f = ($urandom_range(0, 99) < 2);
      drive(v, $urandom, r, f);
    end

    for (int i = 0; i < 4; i++) drive(1'b0, 32'h0, 1'b1, 1'b0);
    #1;
    check("drained_valid", W'(valid_a), W'(1'b0));
    check("drained_occ",   W'(occ_b),   W'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
